free_ptr_queue: RTL and testbench



---
 rtl/free_ptr_queue_pkg.sv | 24 ++
 rtl/free_ptr_queue_fq_mem.sv | 38 +++
 rtl/free_ptr_queue.sv | 133 +++++++++++++
 tb/tb_free_ptr_queue.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/free_ptr_queue_pkg.sv
// ---------------------------------------------------------------------------
// free_ptr_queue_pkg
//   Shared sizing and types for the free-cell pointer queue.
//   FQ_DEPTH  : number of cell pointers managed (power of two)
//   FQ_AW     : log2(FQ_DEPTH), stored pointer width
//   FQ_CNT_W  : occupancy counter width (must hold FQ_DEPTH itself)
//   FQ_OUT_W  : width of the zero-extended head pointer output
// ---------------------------------------------------------------------------
package free_ptr_queue_pkg;

  localparam int FQ_DEPTH = 512;
  localparam int FQ_AW    = 9;
  localparam int FQ_CNT_W = 10;
  localparam int FQ_OUT_W = 10;

  typedef logic [FQ_AW-1:0] cell_ptr_t;

  // INIT loads 0..DEPTH-1 into the RAM; RUN is normal FIFO operation.
  typedef enum logic {
    FQ_INIT = 1'b0,
    FQ_RUN  = 1'b1
  } fq_state_e;

endpackage

// File: rtl/free_ptr_queue_fq_mem.sv
// ---------------------------------------------------------------------------
// fq_mem
//   DEPTH x AW pointer storage: one synchronous write port and one
//   asynchronous (distributed-RAM style) read port, so the queue head is
//   visible in the same cycle it is addressed. No reset / clear of contents.
//   Ports:
//     clk       in  clock (write on rising edge)
//     we_i      in  write enable
//     waddr_i   in  write address
//     wdata_i   in  write data
//     raddr_i   in  read address
//     rdata_o   out combinational read data
// ---------------------------------------------------------------------------
module fq_mem
  import free_ptr_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [AW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [AW-1:0] rdata_o
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/free_ptr_queue.sv
// ---------------------------------------------------------------------------
// free_ptr_queue
//   Free-cell pointer queue for the shared-buffer switch core. After reset it
//   fills itself with pointers 0..DEPTH-1, then behaves as a show-ahead FIFO:
//   the write side pops free pointers, the read side pushes them back.
//   Ports:
//     clk             in   clock, rising edge
//     rstn            in   asynchronous active-low reset
//     ptr_din         in   returned pointer, only [AW-1:0] stored
//     FQ_wr           in   push ptr_din at the tail
//     FQ_rd           in   pop the head
//     ptr_dout_s      out  head pointer (show-ahead), 0 when empty
//     ptr_fifo_empty  out  registered, 1 when FQ_count == 0
//     FQ_act          out  1 once initialisation has finished
//     FQ_count        out  registered number of queued pointers
// ---------------------------------------------------------------------------
module free_ptr_queue
  import free_ptr_queue_pkg::*;
#(
  parameter int DEPTH = FQ_DEPTH,
  parameter int AW    = FQ_AW,
  parameter int OUT_W = FQ_OUT_W,
  parameter int CNT_W = FQ_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [15:0]      ptr_din,
  input  logic             FQ_wr,
  input  logic             FQ_rd,
  output logic [OUT_W-1:0] ptr_dout_s,
  output logic             ptr_fifo_empty,
  output logic             FQ_act,
  output logic [CNT_W-1:0] FQ_count
);

  fq_state_e      state_q, state_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic           empty_q, empty_d;

  logic           do_rd, do_wr, full;
  logic           mem_we;
  logic [AW-1:0]  mem_wdata;
  logic [AW-1:0]  rd_data;

  // Upper pointer bits are don't-care by design.
  logic           unused_din_hi;
  assign unused_din_hi = ^ptr_din[15:AW];

  assign full = (count_q == CNT_W'(DEPTH));

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FQ_INIT;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      empty_q  <= empty_d;
    end
  end

  // Next state. During INIT the write pointer doubles as the init counter:
  // the edge that writes the last cell also moves us to RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FQ_INIT: if (wr_ptr_q == AW'(DEPTH - 1)) state_d = FQ_RUN;
      FQ_RUN:  state_d = FQ_RUN;
      default: state_d = FQ_INIT;
    endcase
  end

  // Outputs / datapath control.
  always_comb begin
    do_rd     = 1'b0;
    do_wr     = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    case (state_q)
      FQ_INIT: begin
        // mem[i] = i, user requests ignored.
        mem_we    = 1'b1;
        mem_wdata = wr_ptr_q;
        wr_ptr_d  = wr_ptr_q + AW'(1);
        count_d   = count_q + CNT_W'(1);
      end
      FQ_RUN: begin
        do_rd = FQ_rd && !empty_q;
        // A push into a full queue is still accepted when a pop frees the
        // slot in the same cycle; the head is read before the edge so the
        // overwrite of mem[rd_ptr] (== wr_ptr when full) is harmless.
        do_wr = FQ_wr && (!full || do_rd);
        mem_we    = do_wr;
        mem_wdata = ptr_din[AW-1:0];
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
      end
      default: ;
    endcase
  end

  assign empty_d = (count_d == '0);

  fq_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (mem_wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign ptr_dout_s     = empty_q ? '0 : OUT_W'(rd_data);
  assign ptr_fifo_empty = empty_q;
  assign FQ_count       = count_q;
  assign FQ_act         = (state_q == FQ_RUN);

endmodule

// File: tb/tb_free_ptr_queue.sv
// ---------------------------------------------------------------------------
// tb_free_ptr_queue
//   Self-checking bench for free_ptr_queue. exp_q holds the pointers the
//   queue should contain, in pop order; pushes append to it and every pop
//   is compared against its front.
// ---------------------------------------------------------------------------
module tb_free_ptr_queue;
  import free_ptr_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic [15:0] ptr_din;
  logic        FQ_wr, FQ_rd;
  logic [9:0]  ptr_dout_s;
  logic        ptr_fifo_empty, FQ_act;
  logic [9:0]  FQ_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  free_ptr_queue dut (
    .clk            (clk),
    .rstn           (rstn),
    .ptr_din        (ptr_din),
    .FQ_wr          (FQ_wr),
    .FQ_rd          (FQ_rd),
    .ptr_dout_s     (ptr_dout_s),
    .ptr_fifo_empty (ptr_fifo_empty),
    .FQ_act         (FQ_act),
    .FQ_count       (FQ_count)
  );

  // One RUN-mode transaction; called at posedge+1, returns at posedge+1.
  task automatic cycle(input bit rd, input bit wr, input logic [15:0] din);
    bit m_rd, m_wr;
    int head_exp;
    logic [8:0] v;
    v = din[8:0];
    head_exp = (exp_q.size() == 0) ? 0 : exp_q[0];
    checks++;
    if (ptr_dout_s !== 10'(head_exp)) begin
      errors++;
      $display("FAIL head: got %0d want %0d", ptr_dout_s, head_exp);
    end
    m_rd = rd && (exp_q.size() > 0);
    m_wr = wr && ((exp_q.size() < 512) || m_rd);
    FQ_rd = rd; FQ_wr = wr; ptr_din = din;
    @(posedge clk); #1;
    FQ_rd = 1'b0; FQ_wr = 1'b0;
    if (m_rd) void'(exp_q.pop_front());
    if (m_wr) exp_q.push_back(int'(v));
    checks++;
    if (FQ_count !== 10'(exp_q.size()) || ptr_fifo_empty !== (exp_q.size() == 0)) begin
      errors++;
      $display("FAIL count: got %0d/empty %0b want %0d/empty %0b",
               FQ_count, ptr_fifo_empty, exp_q.size(), exp_q.size() == 0);
    end
    $display("txn rd=%0b wr=%0b din=%h head_before=%0d count=%0d", rd, wr, din, head_exp, FQ_count);
  endtask

  // Waits out INIT from just after reset release, checking every edge.
  task automatic wait_init();
    for (int k = 1; k <= 512; k++) begin
      @(posedge clk); #1;
      checks++;
      if (FQ_act !== (k == 512) || FQ_count !== 10'(k)) begin
        errors++;
        $display("FAIL init edge %0d: act %0b count %0d want act %0b count %0d",
                 k, FQ_act, FQ_count, k == 512, k);
      end
    end
    checks++;
    if (ptr_fifo_empty !== 1'b0 || ptr_dout_s !== 10'd0) begin
      errors++;
      $display("FAIL init_done: empty %0b head %0d want empty 0 head 0", ptr_fifo_empty, ptr_dout_s);
    end
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(i);
    $display("txn init complete count=%0d", FQ_count);
  endtask

  task automatic test_reset();
    rstn = 1'b0; FQ_rd = 1'b0; FQ_wr = 1'b0; ptr_din = '0;
    #12;
    checks++;
    if (FQ_act !== 1'b0 || FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1 || ptr_dout_s !== 10'd0) begin
      errors++;
      $display("FAIL reset: act %0b count %0d empty %0b head %0d want 0 0 1 0",
               FQ_act, FQ_count, ptr_fifo_empty, ptr_dout_s);
    end
    $display("txn reset held");
  endtask

  task automatic test_init();
    @(posedge clk); #1;
    rstn = 1'b1;
    // Requests during INIT must be ignored (count checked every edge).
    FQ_rd = 1'b1; FQ_wr = 1'b1; ptr_din = 16'h01AB;
    wait_init();
    FQ_rd = 1'b0; FQ_wr = 1'b0;
  endtask

  task automatic test_pop();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0);
    checks++;
    if (ptr_dout_s !== 10'd3 || FQ_count !== 10'd509) begin
      errors++;
      $display("FAIL pop3: head %0d count %0d want 3 509", ptr_dout_s, FQ_count);
    end
  endtask

  task automatic test_push();
    cycle(1'b0, 1'b1, 16'hFC05);
    checks++;
    if (FQ_count !== 10'd510) begin
      errors++;
      $display("FAIL push_count: got %0d want 510", FQ_count);
    end
    for (int i = 0; i < 509; i++) cycle(1'b1, 1'b0, 16'h0);
    checks++;
    if (ptr_dout_s !== 10'd5 || FQ_count !== 10'd1) begin
      errors++;
      $display("FAIL pushed_value: head %0d count %0d want 5 1", ptr_dout_s, FQ_count);
    end
  endtask

  task automatic test_back_to_back();
    int head0;
    for (int i = 0; i < 99; i++) cycle(1'b0, 1'b1, 16'hA000 | 16'((i * 37 + 11) % 512));
    head0 = exp_q[9];
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 16'h5000 | 16'(300 + i));
    checks++;
    if (FQ_count !== 10'd100 || ptr_dout_s !== 10'(exp_q[0])) begin
      errors++;
      $display("FAIL rdwr: count %0d head %0d want 100 %0d", FQ_count, ptr_dout_s, exp_q[0]);
    end
    // After 10 pops the head is the 11th original entry.
    checks++;
    if (exp_q[0] === head0) begin
      // unreachable relationship guard is avoided; compare DUT directly instead
    end
    if (ptr_dout_s === 10'(head0)) begin
      errors++;
      $display("FAIL rdwr_advance: head %0d still equals pre-advance entry %0d", ptr_dout_s, head0);
    end
    for (int i = 0; i < 412; i++) cycle(1'b0, 1'b1, 16'((i * 5 + 2) % 512));
    cycle(1'b0, 1'b1, 16'h0123);
    checks++;
    if (FQ_count !== 10'd512) begin
      errors++;
      $display("FAIL full_push: count %0d want 512", FQ_count);
    end
    cycle(1'b1, 1'b1, 16'h01EE);
    checks++;
    if (FQ_count !== 10'd512) begin
      errors++;
      $display("FAIL full_rdwr: count %0d want 512", FQ_count);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 512; i++) cycle(1'b1, 1'b0, 16'h0);
    checks++;
    if (ptr_fifo_empty !== 1'b1 || FQ_count !== 10'd0 || ptr_dout_s !== 10'd0) begin
      errors++;
      $display("FAIL drained: empty %0b count %0d head %0d want 1 0 0",
               ptr_fifo_empty, FQ_count, ptr_dout_s);
    end
    cycle(1'b1, 1'b0, 16'h0);
    cycle(1'b1, 1'b1, 16'h0007);
    checks++;
    if (ptr_dout_s !== 10'd7 || FQ_count !== 10'd1 || ptr_fifo_empty !== 1'b0) begin
      errors++;
      $display("FAIL empty_rdwr: head %0d count %0d empty %0b want 7 1 0",
               ptr_dout_s, FQ_count, ptr_fifo_empty);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 299; i++) cycle(1'b0, 1'b1, 16'(511 - i));
    checks++;
    if (FQ_count !== 10'd300) begin
      errors++;
      $display("FAIL pre_reset: count %0d want 300", FQ_count);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (FQ_act !== 1'b0 || FQ_count !== 10'd0 || ptr_fifo_empty !== 1'b1 || ptr_dout_s !== 10'd0) begin
      errors++;
      $display("FAIL mid_reset: act %0b count %0d empty %0b head %0d want 0 0 1 0",
               FQ_act, FQ_count, ptr_fifo_empty, ptr_dout_s);
    end
    @(posedge clk); #1;
    rstn = 1'b1;
    wait_init();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_init();
    test_pop();
    test_push();
    test_back_to_back();
    test_drain();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
